// File: rtl/instruction_fetch_unit.sv
// PC and fetch stage in front of a 32x8 combinational ROM: assembles 1/2-byte instructions.
// Latency 2 cycles (1-byte) or 3 cycles (2-byte) to instr_valid; holds outputs while instr_ready is low.
module instruction_fetch_unit #(
  parameter logic [15:0] TWO_BYTE_MASK = 16'h3038,
  parameter logic [3:0]  HALT_OPCODE   = 4'b0001,
  parameter logic [4:0]  RESET_PC      = 5'd0
) (
  input  logic       clk,
  input  logic       reset,
  output logic [4:0] rom_address,
  input  logic [7:0] rom_data,
  input  logic       branch_valid,
  input  logic [4:0] branch_target,
  output logic       instr_valid,
  input  logic       instr_ready,
  output logic [3:0] instr_opcode,
  output logic [3:0] instr_operand,
  output logic [7:0] instr_imm,
  output logic [4:0] instr_pc,
  output logic       halted
);

  typedef enum logic [1:0] {FETCH1, FETCH2, HOLD, HALTED} state_t;

  state_t     state;
  logic [4:0] pc;

  assign rom_address = pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH1;
      pc            <= RESET_PC;
      instr_valid   <= 1'b0;
      instr_opcode  <= 4'h0;
      instr_operand <= 4'h0;
      instr_imm     <= 8'h00;
      instr_pc      <= 5'd0;
      halted        <= 1'b0;
    end else begin
      case (state)
        FETCH1: begin
          if (branch_valid) begin
            pc <= branch_target;
          end else begin
            instr_opcode  <= rom_data[7:4];
            instr_operand <= rom_data[3:0];
            instr_imm     <= 8'h00;
            instr_pc      <= pc;
            pc            <= pc + 5'd1;
            if (TWO_BYTE_MASK[rom_data[7:4]]) begin
              state <= FETCH2;
            end else begin
              state       <= HOLD;
              instr_valid <= 1'b1;
            end
          end
        end
        FETCH2: begin
          if (branch_valid) begin
            pc    <= branch_target;
            state <= FETCH1;
          end else begin
            instr_imm   <= rom_data;
            pc          <= pc + 5'd1;
            state       <= HOLD;
            instr_valid <= 1'b1;
          end
        end
        HOLD: begin
          // A redirect wins even when the held instruction is consumed this cycle.
          if (branch_valid) begin
            pc          <= branch_target;
            state       <= FETCH1;
            instr_valid <= 1'b0;
          end else if (instr_ready) begin
            instr_valid <= 1'b0;
            if (instr_opcode == HALT_OPCODE) begin
              state  <= HALTED;
              halted <= 1'b1;
            end else begin
              state <= FETCH1;
            end
          end
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state <= FETCH1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against an instruction-stream reference model.
module tb_instruction_fetch_unit;

  localparam logic [15:0] MASK = 16'h3038;
  localparam logic [3:0]  HALT = 4'b0001;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rom_address;
  logic [7:0] rom_data;
  logic       branch_valid;
  logic [4:0] branch_target;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_opcode;
  logic [3:0] instr_operand;
  logic [7:0] instr_imm;
  logic [4:0] instr_pc;
  logic       halted;

  logic [7:0] rom [32];
  assign rom_data = rom[rom_address];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .rom_address(rom_address), .rom_data(rom_data),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .instr_imm(instr_imm), .instr_pc(instr_pc), .halted(halted)
  );

  int checks = 0;
  int errors = 0;

  // Model: next instruction starts at exp_pc, its fetch began at cycle start.
  logic [4:0] exp_pc = 5'd0;
  int         t = 0;
  int         start = 0;
  logic       halted_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, t);
    end
  endtask

  function automatic int ilen(input logic [4:0] p);
    return MASK[rom[p][7:4]] ? 2 : 1;
  endfunction

  function automatic logic [7:0] iimm(input logic [4:0] p);
    logic [4:0] q;
    q = p + 5'd1;
    return (ilen(p) == 2) ? rom[q] : 8'h00;
  endfunction

  function automatic logic model_valid();
    return !halted_m && ((t - start) >= ilen(exp_pc));
  endfunction

  task automatic check_outputs();
    logic       ev;
    int         adv;
    logic [4:0] ea;
    ev  = model_valid();
    adv = (halted_m || ev) ? ilen(exp_pc) : (t - start);
    ea  = exp_pc + 5'(adv);
    chk("valid", 32'(instr_valid), 32'(ev));
    chk("halted", 32'(halted), 32'(halted_m));
    chk("rom_address", 32'(rom_address), 32'(ea));
    if (ev) begin
      chk("opcode", 32'(instr_opcode), 32'(rom[exp_pc][7:4]));
      chk("operand", 32'(instr_operand), 32'(rom[exp_pc][3:0]));
      chk("imm", 32'(instr_imm), 32'(iimm(exp_pc)));
      chk("pc", 32'(instr_pc), 32'(exp_pc));
    end
  endtask

  task automatic step(input logic rst, input logic br, input logic [4:0] tgt, input logic rdy);
    logic v;
    v = model_valid();
    reset = rst; branch_valid = br; branch_target = tgt; instr_ready = rdy;
    @(posedge clk); #1;
    t++;
    if (rst) begin
      exp_pc = 5'd0; start = t; halted_m = 1'b0;
    end else if (!halted_m) begin
      if (br) begin
        exp_pc = tgt; start = t;
      end else if (v && rdy) begin
        if (rom[exp_pc][7:4] == HALT) halted_m = 1'b1;
        else begin
          exp_pc = exp_pc + 5'(ilen(exp_pc)); start = t;
        end
      end
    end
    check_outputs();
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, rdy);
  endtask

  initial begin
    int hcnt;
    reset = 1'b1; branch_valid = 1'b0; branch_target = 5'd0; instr_ready = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 8'h20;
    rom[0] = 8'h3C; rom[1] = 8'h00;
    rom[6] = 8'h21; rom[7] = 8'h70;
    rom[8] = 8'h5A; rom[9] = 8'hEE;
    rom[29] = 8'h1F; rom[31] = 8'h40;

    // Reset values
    step(1'b1, 1'b0, 5'd0, 1'b1);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("rst_opcode", 32'(instr_opcode), 32'h0);
    chk("rst_operand", 32'(instr_operand), 32'h0);
    chk("rst_imm", 32'(instr_imm), 32'h0);
    chk("rst_pc", 32'(instr_pc), 32'h0);

    // 2-byte at 0: valid on 3rd cycle after reset
    step(1'b0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b1);
    chk("lat2_valid", 32'(instr_valid), 32'h1);
    chk("lat2_next_addr", 32'(rom_address), 32'd2);
    run(3, 1'b1);

    // 1-byte pair at 6/7
    step(1'b0, 1'b1, 5'd6, 1'b1);
    run(4, 1'b1);

    // Backpressure
    step(1'b0, 1'b1, 5'd6, 1'b0);
    run(6, 1'b0);
    run(3, 1'b1);

    // Branch during FETCH2 of the 2-byte instruction at 8
    step(1'b0, 1'b1, 5'd8, 1'b1);
    step(1'b0, 1'b0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd2, 1'b1);
    chk("br_f2_addr", 32'(rom_address), 32'd2);
    run(3, 1'b1);

    // Branch coinciding with a handshake on a HALT: redirect, no halt
    step(1'b0, 1'b1, 5'd29, 1'b0);
    run(2, 1'b0);
    step(1'b0, 1'b1, 5'd6, 1'b1);
    chk("br_hs_not_halted", 32'(halted), 32'h0);
    run(2, 1'b1);

    // PC wrap with immediate from address 0
    rom[0] = 8'h01;
    step(1'b0, 1'b1, 5'd31, 1'b1);
    run(2, 1'b0);
    chk("wrap_imm", 32'(instr_imm), 32'h01);
    run(2, 1'b1);

    // Halt, then branch ignored, then reset recovers
    step(1'b0, 1'b1, 5'd29, 1'b1);
    run(3, 1'b1);
    chk("halt_addr", 32'(rom_address), 32'd30);
    step(1'b0, 1'b1, 5'd4, 1'b1);
    step(1'b0, 1'b1, 5'd4, 1'b1);
    chk("halt_ign_addr", 32'(rom_address), 32'd30);
    step(1'b1, 1'b0, 5'd0, 1'b1);
    chk("rst_exit_halt", 32'(halted), 32'h0);
    run(3, 1'b1);

    // Randomized traffic with mid-operation resets
    hcnt = 0;
    for (int i = 0; i < 4000; i++) begin
      logic rst, br, rdy;
      rst = ($urandom_range(0, 99) == 0) || (hcnt > 3);
      br  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (rst && ($urandom_range(0, 1) == 0))
        for (int k = 0; k < 32; k++) rom[k] = 8'($urandom);
      step(rst, br, 5'($urandom), rdy);
      hcnt = halted_m ? hcnt + 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Program-counter and fetch stage sitting directly upstream of the 32x8 combinational instruction ROM (5-bit address in, 8-bit data out).
- Drives the ROM address, reads one byte per cycle and assembles 1- or 2-byte instructions.
- Presents each complete instruction to the decoder over a valid/ready handshake.
- Handles branch redirects and the halt instruction.

Parameters:
- TWO_BYTE_MASK, 16'h3038, bit n set means opcode n (upper nibble of first byte) carries an 8-bit immediate in the next byte. Default: opcodes 3, 4, 5, 12, 13.
- HALT_OPCODE, 4'b0001, opcode that stops fetching once accepted.
- RESET_PC, 5'd0, PC value loaded on reset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- rom_address  output  5  ROM address; equals registered PC.
- rom_data  input  8  ROM byte at rom_address, valid same cycle (combinational ROM).
- branch_valid  input  1  one-cycle redirect request from execute.
- branch_target  input  5  new PC when branch_valid=1.
- instr_valid  output  1  instruction outputs hold a complete instruction.
- instr_ready  input  1  decoder accepts when instr_valid & instr_ready.
- instr_opcode  output  4  first byte [7:4].
- instr_operand  output  4  first byte [3:0].
- instr_imm  output  8  second byte for two-byte opcodes; 8'h00 otherwise.
- instr_pc  output  5  address of the first byte.
- halted  output  1  high once a HALT_OPCODE instruction has been accepted.

Behaviour:
- States: FETCH1, FETCH2, HOLD, HALTED. Reset state is FETCH1.
- On reset: pc=RESET_PC; instr_valid=0; instr_opcode, instr_operand, instr_imm, instr_pc =0; halted=0.
- FETCH1: latch rom_data into opcode/operand, instr_pc<=pc, instr_imm<=0, pc<=pc+1.
  - If TWO_BYTE_MASK[rom_data[7:4]] is set: next state FETCH2.
  - Otherwise: next state HOLD.
- FETCH2: latch rom_data into instr_imm, pc<=pc+1, next state HOLD.
- HOLD: instr_valid=1 (registered; high exactly while in HOLD).
  - Outputs are stable until accepted.
  - On instr_valid&instr_ready: next state HALTED if opcode==HALT_OPCODE, else FETCH1.
  - Without ready: remain in HOLD, pc unchanged.
- Latency: first instr_valid 2 cycles after reset deasserts for a 1-byte instruction, 3 cycles for a 2-byte instruction.
- Throughput: one 1-byte instruction per 2 cycles, one 2-byte instruction per 3 cycles (with ready held high).
- HALTED: instr_valid=0, halted=1, pc frozen; branch_valid is ignored. Only reset exits this state.
- Branch (branch_valid=1 in FETCH1/FETCH2/HOLD): pc<=branch_target, next state FETCH1, instr_valid=0 next cycle. Any partial or unaccepted instruction is discarded.
  - Branch has priority over all other transitions.
  - If branch and a handshake occur in the same cycle, the handshaked instruction counts as consumed, and redirect still happens. Halt is not entered even if the consumed instruction is HALT.
- PC arithmetic is 5-bit modulo 32: 31+1 wraps to 0. A 2-byte instruction starting at 31 takes its immediate from address 0.
- Reset mid-operation (any state, including HOLD with valid high) returns to the reset values in the next cycle.
- rom_address is always driven from the pc register (no combinational path from branch_target).

Test Plan:
- Reset, ROM[0]=8'h3C, ROM[1]=8'h00, ready=1 -> valid on the 3rd cycle after reset with opcode 3, operand C, imm 00, pc 0; next fetch address 2.
- ROM[6]=8'h21, ROM[7]=8'h70, ready=1 -> 1-byte instructions {2,1,imm 00,pc 6} then {7,0,imm 00,pc 7} 2 cycles apart.
- Backpressure: ready=0 for 5 cycles while valid -> outputs and rom_address unchanged; ready=1 -> accepted once, next fetch follows.
- branch_valid=1, branch_target=5'd2 while in FETCH2 of a 2-byte instruction -> no valid for that instruction; next fetch address 2; instruction at 2 presented with pc 2.
- PC wrap: branch to 31 with ROM[31]=8'h40, ROM[0]=8'h01 -> instruction {4,0,imm 01,pc 31}; next fetch address 1.
- ROM[29]=8'h1F accepted -> halted=1, valid stays 0, rom_address frozen at 30, branch ignored; reset -> halted=0, fetch from 0.
